// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: extends an immediate by mode and buffers it in a 2-entry FIFO.
// Define IMM_EXT_BRANCH_EN to enable the mode-11 branch-offset shift (else mode 11 = sign-extend).
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
);
    localparam int PAD_W = OUT_W - IN_W;

    generate
        if (OUT_W < IN_W + 2) begin : g_width_check
            $error("imm_extend_pipe: OUT_W must be at least IN_W+2");
        end
    endgenerate

    logic [OUT_W-1:0] w_zext;
    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_upper;
    logic [OUT_W-1:0] w_ext;
    logic             w_push;
    logic             w_pop;
    logic [OUT_W-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    assign w_zext  = {{PAD_W{1'b0}}, in_imm};
    assign w_sext  = {{PAD_W{in_imm[IN_W-1]}}, in_imm};
    assign w_upper = {in_imm, {PAD_W{1'b0}}};

`ifdef IMM_EXT_BRANCH_EN
    logic [OUT_W-1:0] w_branch;
    assign w_branch = {w_sext[OUT_W-3:0], 2'b00};
    always_comb begin
        w_ext = in_mode == 2'b00 ? w_zext :
                in_mode == 2'b01 ? w_sext :
                in_mode == 2'b10 ? w_upper : w_branch;
    end
`else
    always_comb begin
        w_ext = in_mode == 2'b00 ? w_zext :
                in_mode == 2'b10 ? w_upper : w_sext;
    end
`endif

    // Ready depends only on the registered count, so out_ready never reaches in_ready.
    assign in_ready  = r_count < 2'd2;
    assign out_valid = r_count != 2'd0;
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 2; i++) r_mem[i] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_ext;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: scoreboard bench with directed cases and random traffic against an arithmetic model.
module tb_imm_extend_pipe;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_imm = '0;
    logic [1:0]  in_mode = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] sb[$];

    imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_mode(in_mode), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] m);
        longint s;
        longint v;
        s = imm >= 16'h8000 ? longint'(imm) - 65536 : longint'(imm);
        case (m)
            2'd0: v = longint'(imm);
            2'd1: v = s;
            2'd2: v = longint'(imm) * 65536;
`ifdef IMM_EXT_BRANCH_EN
            default: v = s * 4;
`else
            default: v = s;
`endif
        endcase
        return v[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: model state is the queue; handshakes are decided from the model's count.
    always @(negedge Clk) begin
        if (Reset) begin
            sb.delete();
            check("reset_valid", 32'(out_valid), 32'd0);
            check("reset_data", out_data, 32'd0);
            check("reset_ready", 32'(in_ready), 32'd1);
        end else begin
            bit acc;
            acc = in_valid && sb.size() < 2;
            check("in_ready", 32'(in_ready), 32'(sb.size() < 2));
            check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
            check("out_data", out_data, sb.size() != 0 ? sb[0] : 32'd0);
            if (flush) sb.delete();
            else begin
                if (out_ready && sb.size() != 0) void'(sb.pop_front());
                if (acc) sb.push_back(ref_ext(in_imm, in_mode));
            end
        end
    end

    task automatic drive(input bit v, input logic [15:0] imm, input logic [1:0] m,
                         input bit ordy, input bit fl);
        @(posedge Clk);
        #1;
        in_valid = v; in_imm = imm; in_mode = m; out_ready = ordy; flush = fl;
    endtask

    initial begin
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        // Mode examples with a free-flowing consumer
        drive(1, 16'h8000, 2'd0, 1, 0);
        drive(1, 16'h8000, 2'd1, 1, 0);
        drive(1, 16'h8000, 2'd2, 1, 0);
        drive(1, 16'hFFFF, 2'd3, 1, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        check("mode11_value", ref_ext(16'hFFFF, 2'd3),
`ifdef IMM_EXT_BRANCH_EN
              32'hFFFFFFFC);
`else
              32'hFFFFFFFF);
`endif
        // Backpressure: third offer must be refused
        drive(1, 16'h0001, 2'd0, 0, 0);
        drive(1, 16'h0002, 2'd0, 0, 0);
        drive(1, 16'h0003, 2'd0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check("full_ready_low", 32'(in_ready), 32'd0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        check("ready_restored", 32'(in_ready), 32'd1);
        // Simultaneous push and pop at count 1
        drive(1, 16'h0005, 2'd0, 0, 0);
        drive(1, 16'h0006, 2'd0, 1, 0);
        drive(0, 0, 0, 0, 0);
        #4 check("pushpop_data", out_data, 32'h6);
        drive(0, 0, 0, 1, 0);
        // Flush wins over a push with count 2
        drive(1, 16'h0011, 2'd1, 0, 0);
        drive(1, 16'h0022, 2'd1, 0, 0);
        drive(1, 16'h0033, 2'd1, 1, 1);
        drive(0, 0, 0, 1, 0);
        #4 check("flush_valid", 32'(out_valid), 32'd0);
        // Asynchronous reset mid-cycle with count 2
        drive(1, 16'h0044, 2'd2, 0, 0);
        drive(1, 16'h0055, 2'd2, 0, 0);
        drive(0, 0, 0, 0, 0);
        #2 Reset = 1'b1;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_data", out_data, 32'd0);
        @(posedge Clk);
        #1 Reset = 1'b0;
        // Random traffic
        for (int i = 0; i < 3000; i++)
            drive($urandom_range(0, 3) != 0, 16'($urandom), 2'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge Clk);
        @(posedge Clk);
        #4 check("drain_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 Parameter IN_W, default 16: immediate input width in bits.
REQ-002 Parameter OUT_W, default 32: extended output width in bits; SHALL satisfy OUT_W >= IN_W+2, with elaboration failing otherwise.
REQ-003 Clk  input  1  single clock; all state on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  producer offers in_imm/in_mode this cycle.
REQ-006 in_ready  output  1  block can accept an entry this cycle.
REQ-007 in_imm  input  IN_W  raw immediate field.
REQ-008 in_mode  input  2  00 zero-ext, 01 sign-ext, 10 upper (LUI-style), 11 branch offset.
REQ-009 flush  input  1  synchronous discard of all buffered entries.
REQ-010 out_valid  output  1  out_data holds a valid extended immediate.
REQ-011 out_ready  input  1  consumer accepts out_data this cycle.
REQ-012 out_data  output  OUT_W  extended immediate, head of buffer.

Function
REQ-013 Mode 00 SHALL produce in_imm zero-extended to OUT_W.
REQ-014 Mode 01 SHALL produce in_imm with bit IN_W-1 replicated into all upper OUT_W-IN_W bits.
REQ-015 Mode 10 SHALL produce in_imm placed in the top IN_W bits, with low OUT_W-IN_W bits zero; bits beyond OUT_W SHALL be dropped.
REQ-016 Mode 11 SHALL produce the mode-01 result shifted left 2, with the two low bits zero and overflow discarded.
REQ-017 Extension SHALL be computed at input and stored in a 2-entry FIFO; storage SHALL be OUT_W bits per entry.
REQ-018 A push SHALL occur on a rising edge with in_valid=1 and in_ready=1; a pop SHALL occur with out_valid=1 and out_ready=1.
REQ-019 in_ready SHALL equal (count < 2) and SHALL be a registered function of count, with no combinational path from out_ready.
REQ-020 out_valid SHALL equal (count != 0); out_data SHALL be the oldest entry, and 0 when count=0.
REQ-021 Latency SHALL be one cycle: an entry pushed at edge N is visible on out_valid/out_data after edge N; no combinational in->out path SHALL exist.
REQ-022 Simultaneous push and pop with count=1 SHALL keep count=1, present the new entry after the edge, and lose no data.
REQ-023 With count=2, in_ready SHALL be 0, and in_valid SHALL be ignored even if out_ready=1 in the same cycle.
REQ-024 A pop with count=0 SHALL have no effect.
REQ-025 Read/write pointers SHALL wrap modulo 2.
REQ-026 flush=1 at an edge SHALL set count=0, and any simultaneous push or pop SHALL be discarded, so flush wins.
REQ-027 out_data SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-028 Reset=1 SHALL immediately clear count, pointers and storage, independent of Clk.
REQ-029 While Reset=1 and after release: out_valid=0, out_data=0, in_ready=1.
REQ-030 Reset asserted mid-transfer SHALL drop all buffered entries, with no partial output emitted.

Configuration
REQ-031 Macro IMM_EXT_BRANCH_EN defined: mode 11 SHALL behave per REQ-016.
REQ-032 Macro IMM_EXT_BRANCH_EN undefined: mode 11 SHALL behave identically to mode 01, and the shift logic SHALL be absent.

Verification
REQ-033 IN_W=16/OUT_W=32, out_ready=1, push 0x8000 in modes 00, 01, 10 -> out_data 0x00008000, 0xFFFF8000, 0x80000000, each one cycle after its push.
REQ-034 Push 0xFFFF mode 11 -> 0xFFFFFFFC with IMM_EXT_BRANCH_EN defined; 0xFFFFFFFF without it.
REQ-035 out_ready=0, offer 0x0001, 0x0002, 0x0003 mode 00 on consecutive cycles -> in_ready falls after the 2nd push, and 0x0003 is not accepted. Then out_ready=1 -> outputs 0x1, 0x2 in order, and in_ready returns to 1.
REQ-036 count=1 holding 0x0005, simultaneous push 0x0006 and pop -> 0x5 consumed, 0x6 shown next cycle, count stays 1.
REQ-037 count=2 with flush=1 and in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1, and the offered entry is lost.
REQ-038 Reset pulsed asynchronously mid-cycle with count=2 -> out_valid and out_data go to 0 before the next Clk edge, and the buffer is empty after release.
